// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - keypad-to-ALU sequencer for a BCD calculator
// Collects BCD operands and operators, strobes the ALU and captures its result.
module calc_sequencer #(
  parameter int          MAX_DIGITS = 4,
  parameter logic [15:0] NAN_CODE   = 16'hFBAB
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic [15:0] alu_res,
  output logic [15:0] num1,
  output logic [15:0] num2,
  output logic [3:0]  op,
  output logic        exe,
  output logic [15:0] disp,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {ENTER_A, ENTER_B, EXEC, WAIT, CAPTURE, SHOW, ERR} state_t;

  localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);
  localparam logic [3:0] KEY_EQ  = 4'd10;
  localparam logic [3:0] KEY_CLR = 4'd11;
  localparam logic [3:0] OP_ADD  = 4'd12;

  state_t      state, state_n;
  logic [15:0] num1_n, num2_n, result, result_n;
  logic [3:0]  op_n, pend_op, pend_op_n;
  logic [2:0]  cnt, cnt_n;
  logic        pend, pend_n, exe_n;
  logic        is_digit, is_op, digit_ok;

  assign is_digit = key_code <= 4'd9;
  assign is_op    = key_code >= OP_ADD;
  assign digit_ok = cnt < MAX_CNT;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ENTER_A;
      num1    <= '0;
      num2    <= '0;
      op      <= OP_ADD;
      exe     <= 1'b0;
      cnt     <= '0;
      result  <= '0;
      pend    <= 1'b0;
      pend_op <= OP_ADD;
    end else begin
      state   <= state_n;
      num1    <= num1_n;
      num2    <= num2_n;
      op      <= op_n;
      exe     <= exe_n;
      cnt     <= cnt_n;
      result  <= result_n;
      pend    <= pend_n;
      pend_op <= pend_op_n;
    end
  end

  always_comb begin
    state_n   = state;
    num1_n    = num1;
    num2_n    = num2;
    op_n      = op;
    cnt_n     = cnt;
    result_n  = result;
    pend_n    = pend;
    pend_op_n = pend_op;
    // Clear wins over everything, even while the ALU is working.
    if (key_valid && key_code == KEY_CLR) begin
      state_n   = ENTER_A;
      num1_n    = '0;
      num2_n    = '0;
      op_n      = OP_ADD;
      cnt_n     = '0;
      result_n  = '0;
      pend_n    = 1'b0;
      pend_op_n = OP_ADD;
    end else begin
      case (state)
        ENTER_A: if (key_valid) begin
          if (is_digit && digit_ok) begin
            num1_n = {num1[11:0], key_code};
            cnt_n  = cnt + 3'd1;
          end else if (is_op) begin
            op_n    = key_code;
            num2_n  = '0;
            cnt_n   = '0;
            state_n = ENTER_B;
          end
        end
        ENTER_B: if (key_valid) begin
          if (is_digit && digit_ok) begin
            num2_n = {num2[11:0], key_code};
            cnt_n  = cnt + 3'd1;
          end else if (is_op) begin
            if (cnt == 3'd0) begin
              op_n = key_code;
            end else begin
              pend_op_n = key_code;
              pend_n    = 1'b1;
              state_n   = EXEC;
            end
          end else if (key_code == KEY_EQ && cnt != 3'd0) begin
            pend_n  = 1'b0;
            state_n = EXEC;
          end
        end
        EXEC:    state_n = WAIT;
        WAIT:    state_n = CAPTURE;
        CAPTURE: begin
          result_n = alu_res;
          if (alu_res == NAN_CODE) begin
            state_n = ERR;
          end else if (pend) begin
            num1_n  = alu_res;
            op_n    = pend_op;
            num2_n  = '0;
            cnt_n   = '0;
            pend_n  = 1'b0;
            state_n = ENTER_B;
          end else begin
            state_n = SHOW;
          end
        end
        SHOW: if (key_valid) begin
          if (is_digit) begin
            num1_n  = {12'd0, key_code};
            cnt_n   = 3'd1;
            state_n = ENTER_A;
          end else if (is_op) begin
            num1_n  = result;
            op_n    = key_code;
            num2_n  = '0;
            cnt_n   = '0;
            state_n = ENTER_B;
          end
        end
        ERR:     state_n = ERR;
        default: state_n = ENTER_A;
      endcase
    end
    // exe is registered so it is high exactly while the state register holds EXEC.
    exe_n = (state_n == EXEC);
  end

  always_comb begin
    disp = result;
    case (state)
      ENTER_A: disp = num1;
      ENTER_B: disp = (cnt != 3'd0) ? num2 : num1;
      ERR:     disp = NAN_CODE;
      default: disp = result;
    endcase
  end

  assign busy = (state == EXEC) || (state == WAIT) || (state == CAPTURE);
  assign err  = (state == ERR);

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 The block SHALL have parameter MAX_DIGITS, default 4, meaning the maximum BCD digits accepted per operand (1..4).
REQ-002 The block SHALL have parameter NAN_CODE, default 16'hFBAB, meaning the ALU result pattern that flags divide-by-zero.
REQ-003 The block SHALL have port clk, input, 1, meaning the single system clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning reset; synchronous and active-high.
REQ-005 The block SHALL have port key_valid, input, 1, meaning a one-cycle pulse qualifying key_code.
REQ-006 The block SHALL have port key_code, input, 4, meaning 0-9 digit, 10 equals, 11 clear, 12 plus, 13 minus, 14 mult, 15 div.
REQ-007 The block SHALL have port alu_res, input, 16, meaning the BCD result returned by the ALU.
REQ-008 The block SHALL have ports num1 and num2, output, 16 each, meaning the registered BCD operands driven to the ALU.
REQ-009 The block SHALL have port op, output, 4, meaning the registered operator driven to the ALU, using codes 12-15.
REQ-010 The block SHALL have port exe, output, 1, meaning the registered execute strobe to the ALU.
REQ-011 The block SHALL have port disp, output, 16, meaning the BCD value to display.
REQ-012 The block SHALL have ports busy and err, output, 1 each, meaning that a calculation is in flight, and that the error state is active.

Function
REQ-013 The FSM SHALL have exactly these states: ENTER_A, ENTER_B, EXEC, WAIT, CAPTURE, SHOW, ERR.
REQ-014 A digit key in ENTER_A or ENTER_B SHALL shift the active operand left 4 bits and insert the digit in bits [3:0], only while fewer than MAX_DIGITS digits have been entered; further digits SHALL be ignored.
REQ-015 An operator key in ENTER_A SHALL latch op and go to ENTER_B with num2=0 and the digit count at 0.
REQ-016 An operator key in ENTER_B with zero num2 digits SHALL replace op and remain in ENTER_B.
REQ-017 An operator key in ENTER_B with at least one num2 digit SHALL start a chained calculation: record the new operator as pending and go to EXEC.
REQ-018 Equals in ENTER_B with at least one num2 digit SHALL go to EXEC with nothing pending; equals in any other case SHALL be ignored.
REQ-019 EXEC SHALL hold exe=1 for exactly one cycle, then go to WAIT with exe=0 for one cycle, then go to CAPTURE.
REQ-020 In CAPTURE, alu_res SHALL be registered into the result register.
  - alu_res == NAN_CODE: go to ERR.
  - Else, pending operator present: num1 := result, op := pending, num2 := 0, go to ENTER_B.
  - Else: go to SHOW.
REQ-021 busy SHALL be 1 in EXEC, WAIT and CAPTURE, and 0 otherwise; key_valid while busy=1 SHALL be dropped and never queued.
REQ-022 num1, num2 and op SHALL remain stable from entry to EXEC through the end of CAPTURE.
REQ-023 In SHOW:
  - a digit SHALL start a new num1 equal to that digit and go to ENTER_A;
  - an operator SHALL load num1 := result, latch op and go to ENTER_B;
  - equals SHALL be ignored.
REQ-024 In ERR, disp SHALL equal NAN_CODE and err SHALL be 1; every key except clear SHALL be ignored.
REQ-025 disp SHALL equal:
  - num1 in ENTER_A;
  - num2 in ENTER_B once a num2 digit has been entered, else num1;
  - the last result in EXEC, WAIT, CAPTURE and SHOW.
REQ-026 The clear key SHALL act exactly as reset, in any state including busy states, and SHALL take effect on the next edge.
REQ-027 The ALU result SHALL be passed through unmodified (truncation and wrap are the ALU's behaviour); the block SHALL perform no arithmetic except the digit count.

Reset
REQ-028 When rst=1 at a clock edge:
  - state := ENTER_A; num1 = num2 = disp = 0; op = 12; exe = busy = err = 0; digit count = 0; result = 0; pending cleared.
REQ-029 rst SHALL take priority over key_valid in the same cycle, and an assertion during EXEC or WAIT SHALL abort the calculation with exe forced to 0.

Verification
REQ-030 Keys 1,2,plus,3,4,equals; alu_res=0x0046 -> exe pulses once for 1 cycle with num1=0x0012, num2=0x0034, op=12; then disp=0x0046 and state SHOW.
REQ-031 Keys 9,9,9,9,9 -> num1=0x9999 and the 5th digit is ignored; then keys minus, times -> op=14 and num2 stays 0.
REQ-032 Keys 5,div,0,equals; alu_res=0xFBAB -> err=1 and disp=0xFBAB; key 7 is ignored; clear -> all outputs at reset values.
REQ-033 Chain: 2,mult,3,plus with alu_res=0x0006 -> state ENTER_B with num1=0x0006, op=12 and num2=0; then 4,equals -> second exe pulse with num1=0x0006, num2=0x0004.
REQ-034 key_valid asserted every cycle during EXEC, WAIT and CAPTURE -> no operand or op change; rst during WAIT -> exe=0 and ENTER_A on the next cycle.
